// File: rtl/h14tx_island_assembler.sv
// HDMI 1.4 data-island assembler: queues packets and serialises N per island as TERC4
// pre-encode chunks, with on-the-fly BCH parity and null-packet padding.
package h14tx_pkg;
    typedef struct packed {
        logic [23:0]      header;
        logic [0:3][55:0] sub;
    } packet_t;
endpackage

module h14tx_island_assembler
    import h14tx_pkg::*;
#(
    parameter  int FIFO_DEPTH = 4,
    parameter  int MAX_PKTS   = 18,
    localparam int NPW        = $clog2(MAX_PKTS + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_pkt_valid,
    input  packet_t        i_pkt,
    output logic           o_pkt_ready,
    input  logic           i_island_go,
    input  logic [NPW-1:0] i_island_npkt,
    output logic           o_busy,
    output logic           o_chunk_valid,
    output logic [8:0]     o_chunk,
    output logic [4:0]     o_counter,
    output logic           o_pkt_first,
    output logic           o_island_last
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {S_IDLE, S_SEND} state_t;

    // One serial step of g(x) = 1 + x^6 + x^7 + x^8, data LSB first.
    function automatic logic [7:0] bch_step(input logic [7:0] ecc, input logic d);
        return {1'b0, ecc[7:1]} ^ ({8{ecc[0] ^ d}} & 8'h83);
    endfunction

    state_t          r_state, w_state_next;
    packet_t         r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]   r_count, w_count_next;
    logic            r_ready;
    packet_t         r_pkt, w_cur;
    logic [7:0]      r_ecc_h, w_ecc_h, w_ecc_h_next;
    logic [3:0][7:0] r_ecc_s, w_ecc_s, w_ecc_s_next;
    logic [NPW-1:0]  r_pidx, w_pidx_next, r_npkt, w_npkt_next, w_npkt_clamp;
    logic [4:0]      r_counter, w_cnt_next;
    logic [8:0]      r_chunk, w_chunk_next;
    logic            r_busy, r_chunk_valid, r_pkt_first, r_island_last;
    logic            w_advance, w_load, w_push, w_pop, w_empty, w_last_next;
    logic [3:0]      w_lo, w_hi;

    assign w_empty = (r_count == '0);
    assign w_push  = i_pkt_valid && r_ready;
    assign w_pop   = w_load && !w_empty;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_advance    = 1'b0;
        w_load       = 1'b0;
        w_cnt_next   = r_counter + 5'd1;
        w_pidx_next  = r_pidx;
        w_npkt_next  = r_npkt;
        w_npkt_clamp = (i_island_npkt > NPW'(MAX_PKTS)) ? NPW'(MAX_PKTS) : i_island_npkt;
        case (r_state)
            S_IDLE: begin
                if (i_island_go && (w_npkt_clamp != '0)) begin
                    w_state_next = S_SEND;
                    w_advance    = 1'b1;
                    w_load       = 1'b1;
                    w_cnt_next   = '0;
                    w_pidx_next  = '0;
                    w_npkt_next  = w_npkt_clamp;
                end
            end
            S_SEND: begin
                if (r_island_last) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_advance = 1'b1;
                    if (r_counter == 5'd31) begin
                        w_load      = 1'b1;
                        w_pidx_next = r_pidx + NPW'(1);
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        w_last_next = w_advance && (w_cnt_next == 5'd31) && (w_pidx_next == w_npkt_next - NPW'(1));
    end

    // Chunk for the counter about to be emitted; parity state covers all earlier bits.
    always_comb begin
        w_cur   = w_load ? (w_empty ? '0 : r_mem[r_rd_ptr]) : r_pkt;
        w_ecc_h = w_load ? '0 : r_ecc_h;
        w_ecc_s = w_load ? '0 : r_ecc_s;
        w_ecc_h_next = w_ecc_h;
        w_ecc_s_next = w_ecc_s;
        w_lo = '0;
        w_hi = '0;
        w_chunk_next = '0;
        if (w_cnt_next < 5'd24) begin
            w_chunk_next[0] = w_cur.header[w_cnt_next];
            w_ecc_h_next    = bch_step(w_ecc_h, w_cur.header[w_cnt_next]);
        end else begin
            w_chunk_next[0] = w_ecc_h[w_cnt_next[2:0]];
        end
        for (int k = 0; k < 4; k++) begin
            if (w_cnt_next < 5'd28) begin
                w_lo[k] = w_cur.sub[k][{w_cnt_next, 1'b0}];
                w_hi[k] = w_cur.sub[k][{w_cnt_next, 1'b1}];
                w_ecc_s_next[k] = bch_step(bch_step(w_ecc_s[k], w_lo[k]), w_hi[k]);
            end else begin
                w_lo[k] = w_ecc_s[k][{w_cnt_next[1:0], 1'b0}];
                w_hi[k] = w_ecc_s[k][{w_cnt_next[1:0], 1'b1}];
            end
        end
        w_chunk_next[4:1] = w_lo;
        w_chunk_next[8:5] = w_hi;
    end

    assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

    // NOTE: payload storage is not reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_pkt;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_ready       <= 1'b0;
            r_pkt         <= '0;
            r_ecc_h       <= '0;
            r_ecc_s       <= '0;
            r_pidx        <= '0;
            r_npkt        <= '0;
            r_counter     <= '0;
            r_chunk       <= '0;
            r_busy        <= 1'b0;
            r_chunk_valid <= 1'b0;
            r_pkt_first   <= 1'b0;
            r_island_last <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_count       <= w_count_next;
            r_ready       <= (w_count_next != CW'(FIFO_DEPTH));
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_advance) begin
                r_pkt   <= w_cur;
                r_ecc_h <= w_ecc_h_next;
                r_ecc_s <= w_ecc_s_next;
                r_pidx  <= w_pidx_next;
                r_npkt  <= w_npkt_next;
            end
            r_busy        <= w_advance;
            r_chunk_valid <= w_advance;
            r_chunk       <= w_advance ? w_chunk_next : '0;
            r_counter     <= w_advance ? w_cnt_next : '0;
            r_pkt_first   <= w_advance && (w_cnt_next == 5'd0);
            r_island_last <= w_last_next;
        end
    end

    assign o_pkt_ready   = r_ready;
    assign o_busy        = r_busy;
    assign o_chunk_valid = r_chunk_valid;
    assign o_chunk       = r_chunk;
    assign o_counter     = r_counter;
    assign o_pkt_first   = r_pkt_first;
    assign o_island_last = r_island_last;
endmodule
